// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle control sequencer: FSM states,
// supported opcodes and ALU operation codes.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd7
    } state_e;

    localparam logic [6:0] OP_R   = 7'h33;
    localparam logic [6:0] OP_I   = 7'h13;
    localparam logic [6:0] OP_LW  = 7'h03;
    localparam logic [6:0] OP_SW  = 7'h23;
    localparam logic [6:0] OP_BEQ = 7'h63;
    localparam logic [6:0] OP_JAL = 7'h6F;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    function automatic logic is_supported(input logic [6:0] opc);
        case (opc)
            OP_R, OP_I, OP_LW, OP_SW, OP_BEQ, OP_JAL: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/datapath bundle between the sequencer (master) and the
// yIF/yID/yEX datapath (slave).
interface multicycle_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      ins;
    logic             zero;
    logic [31:0]      PCp4;
    logic [31:0]      branch;
    logic [31:0]      jTarget;
    logic [31:0]      PCin;
    logic [31:0]      ir;
    logic             RegWrite;
    logic             ALUSrc;
    logic [2:0]       op;
    logic             MemRead;
    logic             MemWrite;
    logic [2:0]       state;
    logic             halt;
    logic [CNT_W-1:0] retired;

    modport master (
        input  ins, zero, PCp4, branch, jTarget,
        output PCin, ir, RegWrite, ALUSrc, op, MemRead, MemWrite, state, halt, retired
    );

    modport slave (
        output ins, zero, PCp4, branch, jTarget,
        input  PCin, ir, RegWrite, ALUSrc, op, MemRead, MemWrite, state, halt, retired
    );
endinterface

// File: rtl/multicycle_ctrl_alu_op_decode.sv
// Combinational ALU operation select from the latched instruction fields.
module alu_op_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic       bit30_i,
    output logic [2:0] op_o
);
    always_comb begin
        op_o = ALU_ADD;
        if (opcode_i == OP_BEQ) begin
            op_o = ALU_SUB;
        end else if (opcode_i == OP_R) begin
            case (funct3_i)
                3'b110:  op_o = ALU_OR;
                3'b111:  op_o = ALU_AND;
                3'b000:  op_o = bit30_i ? ALU_SUB : ALU_ADD;
                default: op_o = ALU_ADD;
            endcase
        end
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle sequencer: owns the PC and instruction register, steps each
// instruction through FETCH/DECODE/EXEC/MEM/WB and counts retirements.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h28,
    parameter int          CNT_W    = 16
) (
    input logic               clk,
    input logic               reset,
    multicycle_ctrl_if.master bus
);
    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      ir_q, ir_d;
    logic [CNT_W-1:0] ret_q, ret_d;
    logic [6:0]       opc;
    logic [2:0]       dec_op;
    logic             last;
    logic             reg_write, mem_read, mem_write, alu_src, halt;
    logic [2:0]       alu_op;

    assign opc = ir_q[6:0];

    alu_op_decode u_alu_op_decode (
        .opcode_i (ir_q[6:0]),
        .funct3_i (ir_q[14:12]),
        .bit30_i  (ir_q[30]),
        .op_o     (dec_op)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ret_q   <= ret_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        ret_d     = ret_q;
        last      = 1'b0;
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        alu_src   = 1'b0;
        alu_op    = ALU_ADD;
        halt      = 1'b0;

        case (state_q)
            ST_FETCH: begin
                ir_d    = bus.ins;
                state_d = (bus.ins != 32'h0 && is_supported(bus.ins[6:0])) ? ST_DECODE : ST_HALT;
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                if (opc == OP_BEQ)                       last    = 1'b1;
                else if (opc == OP_LW || opc == OP_SW)   state_d = ST_MEM;
                else                                     state_d = ST_WB;
            end
            ST_MEM: begin
                mem_read  = (opc == OP_LW);
                mem_write = (opc == OP_SW);
                if (opc == OP_SW) last    = 1'b1;
                else              state_d = ST_WB;
            end
            ST_WB: begin
                reg_write = 1'b1;
                last      = 1'b1;
            end
            ST_HALT: halt = 1'b1;
            default: state_d = ST_HALT;
        endcase

        // Operand select and ALU op are held for the whole body of the instruction.
        if (state_q == ST_DECODE || state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
            alu_src = !(opc == OP_R || opc == OP_BEQ);
            alu_op  = dec_op;
        end

        if (last) begin
            state_d = ST_FETCH;
            ret_d   = ret_q + CNT_W'(1);
            if (opc == OP_BEQ && bus.zero) pc_d = bus.branch;
            else if (opc == OP_JAL)        pc_d = bus.jTarget;
            else                           pc_d = bus.PCp4;
        end
    end

    assign bus.PCin     = pc_q;
    assign bus.ir       = ir_q;
    assign bus.RegWrite = reg_write;
    assign bus.ALUSrc   = alu_src;
    assign bus.op       = alu_op;
    assign bus.MemRead  = mem_read;
    assign bus.MemWrite = mem_write;
    assign bus.state    = state_q;
    assign bus.halt     = halt;
    assign bus.retired  = ret_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed cases plus random
// instruction streams compared against a per-instruction reference model.
module tb_multicycle_ctrl;
  localparam int W = 91;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.CNT_W(16)) bus();

  multicycle_ctrl #(.RESET_PC(32'h28), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_ir;
  logic [15:0] m_ret;

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] observe();
    return {bus.state, bus.RegWrite, bus.MemRead, bus.MemWrite, bus.ALUSrc, bus.op,
            bus.halt, bus.PCin, bus.retired, bus.ir};
  endfunction

  function automatic logic [W-1:0] pack(input logic [2:0] st, input logic rw, input logic mr,
                                        input logic mw, input logic as, input logic [2:0] op,
                                        input logic h, input logic [31:0] pc,
                                        input logic [15:0] ret, input logic [31:0] ir);
    return {st, rw, mr, mw, as, op, h, pc, ret, ir};
  endfunction

  // ALU op the instruction calls for, straight from the opcode/funct3 rules.
  function automatic logic [2:0] ref_op(input logic [31:0] insn);
    logic [6:0] opc;
    logic [2:0] f3;
    opc = insn[6:0];
    f3  = insn[14:12];
    if (opc == 7'h63) return 3'b110;
    if (opc == 7'h33) begin
      if (f3 == 3'b110) return 3'b001;
      if (f3 == 3'b111) return 3'b000;
      if (f3 == 3'b000 && insn[30]) return 3'b110;
    end
    return 3'b010;
  endfunction

  task automatic model_reset();
    m_pc  = 32'h28;
    m_ir  = 32'h0;
    m_ret = 16'h0;
  endtask

  // Runs up to max_cyc cycles of one instruction; called just after a negedge.
  task automatic run_insn(input string tag, input logic [31:0] insn, input logic z,
                          input logic [31:0] br, input logic [31:0] jt, input int max_cyc);
    int path[$];
    logic [6:0] opc;
    logic as_v;
    int n;
    opc = insn[6:0];
    case (opc)
      7'h03:   path = '{0, 1, 2, 3, 4};
      7'h23:   path = '{0, 1, 2, 3};
      7'h63:   path = '{0, 1, 2};
      default: path = '{0, 1, 2, 4};
    endcase
    as_v = !(opc == 7'h33 || opc == 7'h63);
    foreach (path[k]) begin
      exp_q.push_back(pack(3'(path[k]), path[k] == 4, path[k] == 3 && opc == 7'h03,
                           path[k] == 3 && opc == 7'h23, (path[k] != 0) && as_v,
                           (path[k] == 0) ? 3'b010 : ref_op(insn), 1'b0, m_pc, m_ret,
                           (k == 0) ? m_ir : insn));
    end
    bus.ins     = insn;
    bus.zero    = z;
    bus.PCp4    = m_pc + 32'd4;
    bus.branch  = br;
    bus.jTarget = jt;
    n = (max_cyc < path.size()) ? max_cyc : path.size();
    for (int k = 0; k < n; k++) begin
      check_eq($sformatf("%s_c%0d", tag, k), observe(), exp_q.pop_front());
      @(negedge clk);
    end
    exp_q.delete();
    if (n >= 1) m_ir = insn;
    if (n == path.size()) begin
      m_ret = m_ret + 16'd1;
      if (opc == 7'h63 && z)  m_pc = br;
      else if (opc == 7'h6F)  m_pc = jt;
      else                    m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic apply_reset(input string tag);
    reset = 1'b1;
    @(negedge clk);
    check_eq(tag, observe(), pack(3'd0, 0, 0, 0, 0, 3'b010, 0, 32'h28, 16'h0, 32'h0));
    reset = 1'b0;
    model_reset();
  endtask

  task automatic halt_test(input string tag, input logic [31:0] insn);
    bus.ins = insn;
    check_eq({tag, "_fetch"}, observe(), pack(3'd0, 0, 0, 0, 0, 3'b010, 0, m_pc, m_ret, m_ir));
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      bus.ins  = $urandom();
      bus.zero = 1'($urandom_range(0, 1));
      check_eq($sformatf("%s_h%0d", tag, k), observe(),
               pack(3'd7, 0, 0, 0, 0, 3'b010, 1, m_pc, m_ret, insn));
      @(negedge clk);
    end
    apply_reset({tag, "_rst"});
  endtask

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] opcs [6];
    logic [31:0] r;
    opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F};
    reset       = 1'b1;
    bus.ins     = 32'h0;
    bus.zero    = 1'b0;
    bus.PCp4    = 32'h0;
    bus.branch  = 32'h0;
    bus.jTarget = 32'h0;
    @(negedge clk);
    apply_reset("reset");

    run_insn("radd", 32'h00628033, 1'b0, 32'h40, 32'h100, 99);
    check_eq("radd_pc", bus.PCin, 32'h2C);
    check_eq("radd_ret", bus.retired, 16'd1);
    run_insn("lw", 32'h0002a303, 1'b0, 32'h40, 32'h100, 99);
    check_eq("lw_pc", bus.PCin, 32'h30);
    run_insn("beq_t", 32'h00000063, 1'b1, 32'h40, 32'h100, 99);
    check_eq("beq_t_pc", bus.PCin, 32'h40);
    run_insn("beq_nt", 32'h00000063, 1'b0, 32'h80, 32'h100, 99);
    check_eq("beq_nt_pc", bus.PCin, 32'h44);
    run_insn("jal", 32'h0000006F, 1'b1, 32'h80, 32'h100, 99);
    check_eq("jal_pc", bus.PCin, 32'h100);
    run_insn("r_or", 32'h0062e033, 1'b0, 32'h0, 32'h0, 99);
    run_insn("r_and", 32'h0062f033, 1'b0, 32'h0, 32'h0, 99);
    run_insn("r_sub", 32'h40628033, 1'b1, 32'h0, 32'h0, 99);
    run_insn("addi", 32'h00a28293, 1'b0, 32'h0, 32'h0, 99);
    run_insn("sw", 32'h0062a023, 1'b1, 32'h0, 32'h0, 99);
    check_eq("ret_10", bus.retired, 16'd10);

    for (int i = 0; i < 80; i++) begin
      r = $urandom();
      r[6:0] = opcs[$urandom_range(0, 5)];
      run_insn($sformatf("rnd%0d", i), r, 1'($urandom_range(0, 1)),
               {$urandom_range(0, 32'h3FFF), 2'b00}, {$urandom_range(0, 32'h3FFF), 2'b00}, 99);
    end

    halt_test("halt0", 32'h0);
    run_insn("post_halt", 32'h00628033, 1'b0, 32'h0, 32'h0, 99);
    halt_test("bad_op", 32'h12345637);

    run_insn("sw_rst", 32'h0062a023, 1'b0, 32'h0, 32'h0, 3);
    check_eq("sw_mem", observe(), pack(3'd3, 0, 0, 1, 1, 3'b010, 0, m_pc, m_ret, 32'h0062a023));
    apply_reset("sw_rst_reset");
    check_eq("sw_rst_ret", bus.retired, 16'd0);
    run_insn("after_rst", 32'h00a28293, 1'b0, 32'h0, 32'h0, 99);
    check_eq("after_rst_ret", bus.retired, 16'd1);
    check_eq("after_rst_pc", bus.PCin, 32'h2C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
